// File: rtl/arbitro_paso32bto8b_pkg.sv
// Shared constants for the 4-lane round-robin arbiter that feeds the
// 32b-to-8b serializer: lane count, lane index width and FSM encodings.
package arbitro_paso32bto8b_pkg;

  localparam int NUM_LANES_C = 4;
  localparam int LANE_W      = 2;

  // Controller states; kept as plain constants so older tools can read them.
  localparam logic [1:0] ST_IDLE  = 2'd0;  // no lane holds a word
  localparam logic [1:0] ST_SERVE = 2'd1;  // issuing one word per cycle
  localparam logic [1:0] ST_PAUSA = 2'd2;  // serializer stalled, words waiting

  // Converts a one-hot lane vector to its index (zero when no bit is set).
  function automatic logic [LANE_W-1:0] onehot_to_idx(input logic [NUM_LANES_C-1:0] oh);
    logic [LANE_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_LANES_C; k++) begin
      if (oh[k]) idx = k[LANE_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbitro_paso32bto8b_rr4.sv
// Combinational round-robin picker: returns the first full lane strictly
// after i_last_grant, wrapping 0-1-2-3-0, so the last winner ranks lowest.
module arbitro_rr4
  import arbitro_paso32bto8b_pkg::*;
(
  input  logic [NUM_LANES_C-1:0] i_full,
  input  logic [LANE_W-1:0]      i_last_grant,
  output logic [NUM_LANES_C-1:0] o_pick,
  output logic                   o_found
);

  logic [LANE_W-1:0] w_idx;

  // Scan the lanes starting one past the previous winner; first full one wins.
  always_comb begin
    o_pick  = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_LANES_C; k++) begin
      w_idx = i_last_grant + k[LANE_W-1:0];
      if (!o_found && i_full[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_paso32bto8b.sv
// Four-lane single-word buffers with a round-robin drain into the 32b-to-8b
// serializer. A word accepted at one edge can leave at the next edge; the
// serializer's pausa freezes issuing while still letting empty lanes fill.
module arbitro_paso32bto8b
  import arbitro_paso32bto8b_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic [3:0]        valid_in,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic [3:0]        ready_out,
  input  logic              pausa,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        lane_out,
  output logic [3:0]        grant
);

  logic [DATA_W-1:0] r_buf [NUM_LANES_C];
  logic [3:0]        r_full;
  logic [LANE_W-1:0] r_last_grant;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic [LANE_W-1:0] r_lane_out;
  logic [3:0]        r_grant;
  logic [1:0]        r_state;

  logic [DATA_W-1:0] w_data_in [NUM_LANES_C];
  logic [3:0]        w_pick;
  logic              w_found;
  logic [3:0]        w_drain;
  logic [3:0]        w_accept;
  logic [3:0]        w_full_next;
  logic [LANE_W-1:0] w_sel;
  logic [1:0]        w_state_next;

  assign w_data_in[0] = data_in0;
  assign w_data_in[1] = data_in1;
  assign w_data_in[2] = data_in2;
  assign w_data_in[3] = data_in3;

  arbitro_rr4 u_rr (
    .i_full       (r_full),
    .i_last_grant (r_last_grant),
    .o_pick       (w_pick),
    .o_found      (w_found)
  );

  assign w_sel    = onehot_to_idx(w_pick);
  // A lane drains only when it is the pick and the serializer is not stalled.
  assign w_drain  = w_pick & {4{w_found & ~pausa}};
  // A lane being drained this edge can take a new word at the same edge.
  assign ready_out = {4{~reset}} & (~r_full | w_drain);
  assign w_accept = valid_in & ready_out;

  // Accepting wins over draining, so a same-edge reload keeps the lane full.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign w_full_next[gi] = w_accept[gi] | (r_full[gi] & ~w_drain[gi]);
  end

  // Full flags: cleared by reset, otherwise follow accept/drain.
  always_ff @(posedge clk_f) begin
    if (reset) r_full <= '0;
    else       r_full <= w_full_next;
  end

  // Lane word buffers load on every accepted transfer; contents need no reset.
  always_ff @(posedge clk_f) begin
    for (int k = 0; k < NUM_LANES_C; k++) begin
      if (w_accept[k]) r_buf[k] <= w_data_in[k];
    end
  end

  // Output register: issues the picked word, or idles while stalled/empty.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_lane_out   <= '0;
      r_grant      <= '0;
      r_last_grant <= 2'd3;
    end else if (pausa || !w_found) begin
      // data_out and lane_out hold their last issued values
      r_valid_out <= 1'b0;
      r_grant     <= '0;
    end else begin
      r_data_out   <= r_buf[w_sel];
      r_lane_out   <= w_sel;
      r_grant      <= w_pick;
      r_valid_out  <= 1'b1;
      r_last_grant <= w_sel;
    end
  end

  // Controller state: tracks whether words are waiting and whether stalled.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|r_full) w_state_next = pausa ? ST_PAUSA : ST_SERVE;
      end
      ST_SERVE: begin
        if (pausa)              w_state_next = ST_PAUSA;
        else if (~|w_full_next) w_state_next = ST_IDLE;
      end
      ST_PAUSA: begin
        if (!pausa) w_state_next = ST_SERVE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_f) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign lane_out  = r_lane_out;
  assign grant     = r_grant;

endmodule

// File: tb/tb_arbitro_paso32bto8b.sv
// Bench for arbitro_paso32bto8b: a directed table of per-cycle vectors,
// then randomized traffic checked against a lane-occupancy reference model.
module tb_arbitro_paso32bto8b;

  logic        clk_f = 1'b0;
  logic        reset;
  logic [3:0]  valid_in;
  logic [31:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0]  ready_out;
  logic        pausa;
  logic [31:0] data_out;
  logic        valid_out;
  logic [1:0]  lane_out;
  logic [3:0]  grant;

  always #5 clk_f = ~clk_f;

  arbitro_paso32bto8b #(.DATA_W(32), .NUM_LANES(4)) dut (
    .clk_f     (clk_f),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .data_in3  (data_in3),
    .ready_out (ready_out),
    .pausa     (pausa),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_out  (lane_out),
    .grant     (grant)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  vin;
    logic        pa;
    logic [31:0] d0, d1, d2, d3;
    logic [3:0]  erdy;   // ready_out just before the edge
    logic        evo;    // outputs just after the edge
    logic [1:0]  elane;
    logic [3:0]  egnt;
    logic [31:0] edout;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic p,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d,
                              input logic [3:0] rdy, input logic vo,
                              input logic [1:0] ln, input logic [3:0] g,
                              input logic [31:0] dout);
    vec_t t;
    t.rst = r; t.vin = v; t.pa = p; t.d0 = a; t.d1 = b; t.d2 = c; t.d3 = d;
    t.erdy = rdy; t.evo = vo; t.elane = ln; t.egnt = g; t.edout = dout;
    return t;
  endfunction

  // Apply one cycle of inputs at the falling edge, check ready before the
  // rising edge and the registered outputs 1 time unit after it.
  task automatic apply(input logic r, input logic [3:0] v, input logic p,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    @(negedge clk_f);
    reset = r; valid_in = v; pausa = p;
    data_in0 = a; data_in1 = b; data_in2 = c; data_in3 = d;
    #1;
  endtask

  // ---------------- reference model (lane occupancy + round-robin pointer)
  bit          m_full [4];
  logic [31:0] m_buf  [4];
  int          m_last;
  logic [31:0] m_dout;
  logic [1:0]  m_lane;
  logic [3:0]  m_grant;
  logic        m_vo;

  initial begin
    reset = 1'b0; valid_in = '0; pausa = 1'b0;
    data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
  end

  initial begin
    // Reset for two edges with all lanes requesting.
    tbl[0]  = mk(1, 4'hF, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 2'd0, 4'h0, 32'h0);
    tbl[1]  = mk(1, 4'hF, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 2'd0, 4'h0, 32'h0);
    tbl[2]  = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 0, 2'd0, 4'h0, 32'h0);
    // Round-robin: all lanes load together, drained 0,1,2,3.
    tbl[3]  = mk(0, 4'hF, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'hF, 0, 2'd0, 4'h0, 32'h0);
    tbl[4]  = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 1, 2'd0, 4'b0001, 32'hA0);
    tbl[5]  = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 1, 2'd1, 4'b0010, 32'hA1);
    tbl[6]  = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0111, 1, 2'd2, 4'b0100, 32'hA2);
    tbl[7]  = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1111, 1, 2'd3, 4'b1000, 32'hA3);
    tbl[8]  = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 0, 2'd3, 4'h0, 32'hA3);
    // Single lane 2, one-cycle latency.
    tbl[9]  = mk(0, 4'b0100, 0, 32'h0, 32'h0, 32'hABCDEFFF, 32'h0, 4'hF, 0, 2'd3, 4'h0, 32'hA3);
    tbl[10] = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 1, 2'd2, 4'b0100, 32'hABCDEFFF);
    tbl[11] = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 0, 2'd2, 4'h0, 32'hABCDEFFF);
    // Pausa: lanes 0 and 3 full, stall 3 cycles, then 3 before 0 (last was 2).
    tbl[12] = mk(0, 4'b1001, 0, 32'h11110000, 32'h0, 32'h0, 32'h33330003, 4'hF, 0, 2'd2, 4'h0, 32'hABCDEFFF);
    tbl[13] = mk(0, 4'h0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0110, 0, 2'd2, 4'h0, 32'hABCDEFFF);
    tbl[14] = mk(0, 4'h0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0110, 0, 2'd2, 4'h0, 32'hABCDEFFF);
    tbl[15] = mk(0, 4'h0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0110, 0, 2'd2, 4'h0, 32'hABCDEFFF);
    tbl[16] = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1110, 1, 2'd3, 4'b1000, 32'h33330003);
    tbl[17] = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 1, 2'd0, 4'b0001, 32'h11110000);
    tbl[18] = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 0, 2'd0, 4'h0, 32'h11110000);
    // Reload: lane 1 streams two words back to back, ready stays high.
    tbl[19] = mk(0, 4'b0010, 0, 32'h0, 32'hADBDCDDD, 32'h0, 32'h0, 4'hF, 0, 2'd0, 4'h0, 32'h11110000);
    tbl[20] = mk(0, 4'b0010, 0, 32'h0, 32'h01020403, 32'h0, 32'h0, 4'hF, 1, 2'd1, 4'b0010, 32'hADBDCDDD);
    tbl[21] = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 1, 2'd1, 4'b0010, 32'h01020403);
    tbl[22] = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 0, 2'd1, 4'h0, 32'h01020403);
    // Reset with three lanes full (held by pausa): nothing stale afterwards.
    tbl[23] = mk(0, 4'b0111, 1, 32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'h0, 4'hF, 0, 2'd1, 4'h0, 32'h01020403);
    tbl[24] = mk(1, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 2'd0, 4'h0, 32'h0);
    tbl[25] = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 0, 2'd0, 4'h0, 32'h0);
    tbl[26] = mk(0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 0, 2'd0, 4'h0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].rst, tbl[i].vin, tbl[i].pa, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
      chk($sformatf("vec%0d ready_out", i), {28'h0, ready_out}, {28'h0, tbl[i].erdy});
      @(posedge clk_f); #1;
      chk($sformatf("vec%0d valid_out", i), {31'h0, valid_out}, {31'h0, tbl[i].evo});
      chk($sformatf("vec%0d grant", i), {28'h0, grant}, {28'h0, tbl[i].egnt});
      chk($sformatf("vec%0d lane_out", i), {30'h0, lane_out}, {30'h0, tbl[i].elane});
      chk($sformatf("vec%0d data_out", i), data_out, tbl[i].edout);
      $display("vec %0d: rst=%0b vin=%h pausa=%0b -> rdy=%h vo=%0b lane=%0d grant=%h data=%h",
               i, tbl[i].rst, tbl[i].vin, tbl[i].pa, ready_out, valid_out, lane_out, grant, data_out);
    end

    // ---------------- randomized traffic against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        r, p, found;
      logic [3:0]  v, erdy;
      logic [31:0] d [4];
      int          pk;
      r = (cyc == 0) || ($urandom_range(0, 79) == 0);
      p = ($urandom_range(0, 3) == 0);
      v = 4'($urandom);
      for (int k = 0; k < 4; k++) d[k] = $urandom;

      // Next lane in circular order after the last winner that holds a word.
      found = 1'b0; pk = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && m_full[(m_last + k) % 4]) begin
          found = 1'b1; pk = (m_last + k) % 4;
        end
      end
      for (int k = 0; k < 4; k++)
        erdy[k] = !r && (!m_full[k] || (found && !p && pk == k));

      apply(r, v, p, d[0], d[1], d[2], d[3]);
      chk($sformatf("rnd%0d ready_out", cyc), {28'h0, ready_out}, {28'h0, erdy});
      @(posedge clk_f); #1;

      if (r) begin
        for (int k = 0; k < 4; k++) m_full[k] = 0;
        m_last = 3; m_dout = '0; m_lane = '0; m_grant = '0; m_vo = 1'b0;
      end else begin
        if (!p && found) begin
          m_dout = m_buf[pk]; m_lane = 2'(pk); m_grant = 4'(1 << pk);
          m_vo = 1'b1; m_last = pk; m_full[pk] = 0;
        end else begin
          m_vo = 1'b0; m_grant = '0;
        end
        for (int k = 0; k < 4; k++) begin
          if (v[k] && erdy[k]) begin
            m_buf[k] = d[k]; m_full[k] = 1;
          end
        end
      end

      chk($sformatf("rnd%0d valid_out", cyc), {31'h0, valid_out}, {31'h0, m_vo});
      chk($sformatf("rnd%0d grant", cyc), {28'h0, grant}, {28'h0, m_grant});
      chk($sformatf("rnd%0d lane_out", cyc), {30'h0, lane_out}, {30'h0, m_lane});
      chk($sformatf("rnd%0d data_out", cyc), data_out, m_dout);
      $display("rnd %0d: rst=%0b vin=%h pausa=%0b -> rdy=%h vo=%0b lane=%0d grant=%h data=%h",
               cyc, r, v, p, ready_out, valid_out, lane_out, grant, data_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_paso32bto8b.md
ARBITRO_PASO32BTO8B -- requirements
Module: arbitro_paso32bto8b

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of every data word.
REQ-002 SHALL have parameter NUM_LANES, default 4, number of requesters; only 4 supported.
REQ-003 SHALL have port clk_f  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  4  per-lane word-valid, bit i for lane i.
REQ-006 SHALL have ports data_in0..data_in3  input  DATA_W each  per-lane words.
REQ-007 SHALL have port ready_out  output  4  per-lane accept; transfer on lane i when valid_in[i] & ready_out[i] at an edge.
REQ-008 SHALL have port pausa  input  1  downstream stall from the 32b-to-8b serializer.
REQ-009 SHALL have port data_out  output  DATA_W  word to the serializer.
REQ-010 SHALL have port valid_out  output  1  data_out valid this cycle.
REQ-011 SHALL have port lane_out  output  2  source lane of data_out.
REQ-012 SHALL have port grant  output  4  one-hot granted lane, all-zero when valid_out=0.

Function
REQ-013 SHALL hold one DATA_W buffer plus full flag per lane.
REQ-014 SHALL drive ready_out[i] = ~full[i] | (lane i granted this cycle & ~pausa), combinationally from registered state and pausa.
REQ-015 SHALL, on an accepted transfer, load the lane buffer and set full at that edge.
REQ-016 SHALL pick, each cycle with pausa=0, the first full lane after last_grant in round-robin order 0-1-2-3-0; last_grant resets to 3, so lane 0 has first priority.
REQ-017 SHALL register the pick: data_out, lane_out, grant, valid_out=1 at the next edge; that buffer's full clears at the same edge.
REQ-018 SHALL reload a lane buffer and keep full=1 when drain and accept hit the same lane on the same edge.
REQ-019 SHALL give minimum latency of 1 cycle: word accepted at edge N appears at the output after edge N+1.
REQ-020 SHALL, while pausa=1, set valid_out=0 and grant=0, keep data_out and lane_out, freeze last_grant, and drain nothing.
REQ-021 SHALL keep a 2-bit FSM: IDLE (no full lane), SERVE (issuing), PAUSA (stalled with a full lane).
REQ-022 SHALL transition IDLE->SERVE on any full & ~pausa, IDLE->PAUSA on any full & pausa, SERVE->PAUSA on pausa, PAUSA->SERVE on ~pausa, and SERVE->IDLE when no lane is full after the drain.
REQ-023 SHALL issue at most one word per cycle, never grant an empty lane, and never drop or duplicate a word.
REQ-024 SHALL, with all four lanes continuously full and pausa=0, grant 0,1,2,3,0,... in consecutive cycles.

Reset
REQ-025 SHALL, on reset=1 at an edge, clear all full flags, data_out=0, valid_out=0, lane_out=0, grant=0, last_grant=3, and set FSM to IDLE.
REQ-026 SHALL have reset take priority over any simultaneous accept or drain; words in flight are discarded.
REQ-027 SHALL hold ready_out=0 while reset=1.

Structure
REQ-028 SHALL place NUM_LANES, lane index width, and FSM state encodings in a shared package.
REQ-029 SHALL split round-robin selection into a combinational sub-module arbitro_rr4 (inputs full[3:0], last_grant; outputs one-hot pick and found).

Verification
REQ-030 SHALL test reset: reset=1 for two edges with valid_in=4'hF -> valid_out=0, grant=0, ready_out=0; first post-reset edge gives ready_out=4'hF.
REQ-031 SHALL test a single lane: lane 2 sends 32'hABCDEFFF at edge N -> data_out=32'hABCDEFFF, lane_out=2, grant=4'b0100 after edge N+1.
REQ-032 SHALL test round-robin: all lanes load 32'h000000L0+i at the same edge -> output order lanes 0,1,2,3 on four consecutive cycles, then valid_out=0.
REQ-033 SHALL test pausa: two lanes full, pausa=1 for 3 cycles -> valid_out=0 throughout and both words emitted after release, in round-robin order.
REQ-034 SHALL test reload: lane 1 continuously valid with 32'hADBDCDDD, then 32'h01020403 -> back-to-back output, ready_out[1] stays 1.
REQ-035 SHALL test reset mid-operation: reset asserted with 3 lanes full -> all flags clear, and no stale word is emitted afterwards.
